// File: rtl/arm_pkg.sv
// ---------------------------------------------------------------------------
// arm_pkg : shared state encodings, position width and mode constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package arm_pkg;

  localparam int POS_W = 8;

  localparam logic MODE_ACCEL    = 1'b0;
  localparam logic MODE_PLAYBACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCEL = 3'd1,
    ST_FETCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
    logic [POS_W-1:0] z;
  } pos_t;

endpackage

`default_nettype wire

// File: rtl/dwell_timer.sv
// ---------------------------------------------------------------------------
// dwell_timer : loadable down-counter, terminal count on the last hold cycle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dwell_timer #(
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_value,
  input  logic               i_en,
  output logic               o_tc
);

  logic [DWELL_W-1:0] r_cnt;

  // A zero hold request still holds for one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= (i_value == '0) ? DWELL_W'(1) : i_value;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = i_en && (r_cnt == DWELL_W'(1));

endmodule

`default_nettype wire

// File: rtl/arm_playback_seq.sv
// ---------------------------------------------------------------------------
// arm_playback_seq : accelerometer tracking / trajectory ROM playback control
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arm_playback_seq
  import arm_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int DWELL_W = 24,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_enable,
  input  logic               i_btn_mem,
  input  logic               i_loop_en,
  input  logic [ADDR_W-1:0]  i_last_addr,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [POS_W-1:0]   i_data_accel_x,
  input  logic [POS_W-1:0]   i_data_accel_y,
  input  logic [POS_W-1:0]   i_data_accel_z,
  input  logic               i_accel_valid,
  input  logic [POS_W-1:0]   i_rom_data_x,
  input  logic [POS_W-1:0]   i_rom_data_y,
  input  logic [POS_W-1:0]   i_rom_data_z,
  output logic [ADDR_W-1:0]  o_rom_addr,
  output logic [POS_W-1:0]   o_data_out_x,
  output logic [POS_W-1:0]   o_data_out_y,
  output logic [POS_W-1:0]   o_data_out_z,
  output logic               o_busy,
  output logic               o_seq_done,
  output logic [2:0]         o_state
);

  localparam int LAT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

  state_t             r_state;
  state_t             w_next;
  logic [LAT_W-1:0]   r_fcnt;
  logic [LAT_W-1:0]   w_fcnt_nxt;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic [ADDR_W-1:0]  r_last;
  logic [ADDR_W-1:0]  w_last_nxt;
  logic [DWELL_W-1:0] r_dwell;
  logic [DWELL_W-1:0] w_dwell_nxt;
  pos_t               r_pos;
  pos_t               w_pos_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_busy;
  logic               w_fetch_done;
  logic               w_at_last;
  logic               w_tc;
  logic               w_load;

  assign w_fetch_done = (r_state == ST_FETCH) && (r_fcnt == LAT_W'(ROM_LAT));
  assign w_at_last    = (r_addr == r_last);
  assign w_load       = w_fetch_done && (w_next == ST_HOLD);

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_value (r_dwell),
    .i_en    (r_state == ST_HOLD),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!i_enable) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = (i_btn_mem == MODE_ACCEL) ? ST_ACCEL : ST_FETCH;
        ST_ACCEL: if (i_btn_mem == MODE_PLAYBACK) w_next = ST_FETCH;
        ST_FETCH: begin
          if (i_btn_mem == MODE_ACCEL) w_next = ST_ACCEL;
          else if (w_fetch_done)       w_next = ST_HOLD;
        end
        ST_HOLD: begin
          if (i_btn_mem == MODE_ACCEL) w_next = ST_ACCEL;
          else if (w_tc)               w_next = (w_at_last && !i_loop_en) ? ST_DONE : ST_FETCH;
        end
        ST_DONE:  if (i_btn_mem == MODE_ACCEL) w_next = ST_ACCEL;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_addr_nxt  = r_addr;
    w_last_nxt  = r_last;
    w_dwell_nxt = r_dwell;
    w_pos_nxt   = r_pos;
    w_fcnt_nxt  = r_fcnt;
    w_done_nxt  = 1'b0;

    if ((r_state == ST_ACCEL) && i_accel_valid) begin
      w_pos_nxt = {i_data_accel_x, i_data_accel_y, i_data_accel_z};
    end

    if ((w_next == ST_FETCH) && (r_state != ST_FETCH)) begin
      w_fcnt_nxt = '0;
    end else if (r_state == ST_FETCH) begin
      w_fcnt_nxt = r_fcnt + 1'b1;
    end

    // Fresh sequence entry: restart at 0 and capture the run parameters.
    if ((w_next == ST_FETCH) && (r_state != ST_FETCH) && (r_state != ST_HOLD)) begin
      w_addr_nxt  = '0;
      w_last_nxt  = i_last_addr;
      w_dwell_nxt = i_dwell;
    end

    if ((r_state == ST_HOLD) && (w_next == ST_FETCH)) begin
      w_addr_nxt = w_at_last ? '0 : r_addr + 1'b1;
      w_done_nxt = w_at_last;
    end

    if ((r_state == ST_HOLD) && (w_next == ST_DONE)) begin
      w_done_nxt = 1'b1;
    end

    if (w_load) begin
      w_pos_nxt = {i_rom_data_x, i_rom_data_y, i_rom_data_z};
    end

    if (((r_state == ST_FETCH) || (r_state == ST_HOLD)) && (w_next == ST_ACCEL)) begin
      w_addr_nxt = '0;
    end

    if (!i_enable) begin
      w_addr_nxt = '0;
      w_pos_nxt  = '0;
      w_fcnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr  <= '0;
      r_last  <= '0;
      r_dwell <= '0;
      r_pos   <= '0;
      r_fcnt  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_last  <= w_last_nxt;
      r_dwell <= w_dwell_nxt;
      r_pos   <= w_pos_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_next == ST_FETCH) || (w_next == ST_HOLD);
    end
  end

  assign o_rom_addr   = r_addr;
  assign o_data_out_x = r_pos.x;
  assign o_data_out_y = r_pos.y;
  assign o_data_out_z = r_pos.z;
  assign o_busy       = r_busy;
  assign o_seq_done   = r_done;
  assign o_state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_arm_playback_seq.sv
// ---------------------------------------------------------------------------
// tb_arm_playback_seq : directed self-checking bench for arm_playback_seq
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_arm_playback_seq;

  localparam int ADDR_W  = 6;
  localparam int DWELL_W = 24;
  localparam int ROM_LAT = 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               i_enable = 1'b0;
  logic               i_btn_mem = 1'b0;
  logic               i_loop_en = 1'b0;
  logic [ADDR_W-1:0]  i_last_addr = '0;
  logic [DWELL_W-1:0] i_dwell = '0;
  logic [7:0]         i_ax = '0, i_ay = '0, i_az = '0;
  logic               i_accel_valid = 1'b0;
  logic [7:0]         r_rom_x = '0, r_rom_y = '0, r_rom_z = '0;
  logic [ADDR_W-1:0]  o_rom_addr;
  logic [7:0]         o_x, o_y, o_z;
  logic               o_busy, o_seq_done;
  logic [2:0]         o_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // One-cycle synchronous ROM: addr n holds {n, n+16, n+32}.
  always @(posedge clk) begin
    r_rom_x <= 8'(o_rom_addr);
    r_rom_y <= 8'(o_rom_addr) + 8'd16;
    r_rom_z <= 8'(o_rom_addr) + 8'd32;
  end

  arm_playback_seq #(
    .ADDR_W (ADDR_W), .DWELL_W (DWELL_W), .ROM_LAT (ROM_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (i_enable),
    .i_btn_mem      (i_btn_mem),
    .i_loop_en      (i_loop_en),
    .i_last_addr    (i_last_addr),
    .i_dwell        (i_dwell),
    .i_data_accel_x (i_ax),
    .i_data_accel_y (i_ay),
    .i_data_accel_z (i_az),
    .i_accel_valid  (i_accel_valid),
    .i_rom_data_x   (r_rom_x),
    .i_rom_data_y   (r_rom_y),
    .i_rom_data_z   (r_rom_z),
    .o_rom_addr     (o_rom_addr),
    .o_data_out_x   (o_x),
    .o_data_out_y   (o_y),
    .o_data_out_z   (o_z),
    .o_busy         (o_busy),
    .o_seq_done     (o_seq_done),
    .o_state        (o_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called in the first cycle of FETCH at address 0; walks one full pass.
  task automatic play(input int last, input int hold, input bit looping);
    for (int wp = 0; wp <= last; wp++) begin
      check("fetch_addr", 32'(o_rom_addr), wp);
      check("fetch_state", 32'(o_state), 2);
      check("fetch_busy", 32'(o_busy), 1);
      tick();
      check("fetch_len", 32'(o_state), 2);
      tick();
      check("hold_state", 32'(o_state), 3);
      check("wp_x", 32'(o_x), wp);
      check("wp_y", 32'(o_y), wp + 16);
      check("wp_z", 32'(o_z), wp + 32);
      for (int k = 1; k < hold; k++) begin
        tick();
        check("hold_len", 32'(o_state), 3);
        check("no_done", 32'(o_seq_done), 0);
      end
      tick();
      if (wp == last) begin
        check("seq_done", 32'(o_seq_done), 1);
        if (looping) begin
          check("wrap_state", 32'(o_state), 2);
          check("wrap_addr", 32'(o_rom_addr), 0);
        end else begin
          check("done_state", 32'(o_state), 4);
          check("done_x", 32'(o_x), last);
        end
      end
    end
  endtask

  initial begin
    // Reset
    tick(); tick();
    check("rst_state", 32'(o_state), 0);
    check("rst_addr", 32'(o_rom_addr), 0);
    check("rst_x", 32'(o_x), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_done", 32'(o_seq_done), 0);

    // Accelerometer tracking
    rst = 1'b1; i_enable = 1'b1; i_btn_mem = 1'b0;
    tick();
    check("accel_state", 32'(o_state), 1);
    i_ax = 8'h40; i_ay = 8'h41; i_az = 8'h42; i_accel_valid = 1'b1;
    check("accel_pre", 32'(o_x), 0);
    tick();
    check("accel_x", 32'(o_x), 32'h40);
    check("accel_y", 32'(o_y), 32'h41);
    check("accel_z", 32'(o_z), 32'h42);
    check("accel_busy", 32'(o_busy), 0);
    i_accel_valid = 1'b0; i_ax = 8'h55;
    tick();
    check("accel_hold", 32'(o_x), 32'h40);

    // Single pass, stop in DONE
    i_last_addr = 6'd3; i_dwell = 24'd4; i_loop_en = 1'b0; i_btn_mem = 1'b1;
    tick();
    play(3, 4, 1'b0);
    tick();
    check("done_pulse_end", 32'(o_seq_done), 0);
    check("done_stay", 32'(o_state), 4);
    check("done_addr", 32'(o_rom_addr), 3);
    check("done_y", 32'(o_y), 19);
    check("done_z", 32'(o_z), 35);

    // Three loops
    i_btn_mem = 1'b0;
    tick();
    check("done_to_accel", 32'(o_state), 1);
    i_loop_en = 1'b1; i_btn_mem = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) play(3, 4, 1'b1);

    // Abort during HOLD of addr 2; mid-run parameter changes are ignored
    i_last_addr = 6'd1; i_dwell = 24'd7;
    repeat (14) tick();
    check("abort_pre_state", 32'(o_state), 3);
    check("abort_pre_addr", 32'(o_rom_addr), 2);
    tick();
    i_btn_mem = 1'b0;
    tick();
    check("abort_state", 32'(o_state), 1);
    check("abort_addr", 32'(o_rom_addr), 0);
    check("abort_done", 32'(o_seq_done), 0);
    check("abort_busy", 32'(o_busy), 0);
    check("abort_x", 32'(o_x), 2);
    i_btn_mem = 1'b1; i_loop_en = 1'b0; i_last_addr = 6'd3; i_dwell = 24'd4;
    tick();
    i_last_addr = 6'd1; i_dwell = 24'd7;
    play(3, 4, 1'b0);

    // Disable during FETCH
    i_btn_mem = 1'b0;
    tick();
    i_btn_mem = 1'b1;
    tick();
    tick();
    i_enable = 1'b0;
    tick();
    check("dis_state", 32'(o_state), 0);
    check("dis_addr", 32'(o_rom_addr), 0);
    check("dis_x", 32'(o_x), 0);
    check("dis_busy", 32'(o_busy), 0);

    // dwell = 0 gives one-cycle holds
    i_enable = 1'b1; i_last_addr = 6'd1; i_dwell = 24'd0; i_loop_en = 1'b0;
    tick();
    play(1, 1, 1'b0);

    // Single waypoint looping
    i_loop_en = 1'b1; i_last_addr = 6'd0;
    i_btn_mem = 1'b0;
    tick();
    i_btn_mem = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) play(0, 1, 1'b1);

    // Reset during HOLD, then a fresh run picks up new parameters
    i_last_addr = 6'd3; i_dwell = 24'd5; i_loop_en = 1'b0;
    tick(); tick();
    check("mid_hold", 32'(o_state), 3);
    rst = 1'b0;
    tick();
    check("rst2_state", 32'(o_state), 0);
    check("rst2_addr", 32'(o_rom_addr), 0);
    check("rst2_x", 32'(o_x), 0);
    check("rst2_busy", 32'(o_busy), 0);
    check("rst2_done", 32'(o_seq_done), 0);
    rst = 1'b1;
    tick();
    play(3, 5, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
